pb_debounce: RTL



---
 rtl/pb_pkg.sv | 28 ++
 rtl/pb_debounce_ch.sv | 174 +++++++++++++++++
 rtl/pb_debounce.sv | 61 ++++++
 3 files changed

// File: rtl/pb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_pkg
//  Description : Shared types and sizing helpers for the pushbutton
//                conditioner (channel state encoding, counter widths).
//  Revision    : 1.0 - initial release
// ============================================================================
package pb_pkg;

  // Per-channel debounce state. RELEASED/PRESSED are the settled levels,
  // the *_PEND states are qualifying a candidate level change.
  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_PEND   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_PEND = 2'd3
  } pb_state_e;

  // Width of a counter that must hold every value 0..max_count inclusive.
  function automatic int cnt_width(input int max_count);
    if (max_count < 1) begin
      return 1;
    end
    return $clog2(max_count + 1);
  endfunction

endpackage : pb_pkg
`default_nettype wire

// File: rtl/pb_debounce_ch.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce_ch
//  Description : One pushbutton channel: 2-FF synchroniser, polarity
//                normalisation, debounce FSM with stability counter, hold
//                counter and registered level / press / release / long
//                strobes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce_ch
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pb_raw_i,
  output logic level_o,
  output logic level_next_o,
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int                DB_W      = cnt_width(DEBOUNCE_CYCLES);
  localparam int                HOLD_W    = cnt_width(LONG_PRESS_CYCLES);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  // Pin level of an untouched button; the synchroniser resets to it so that
  // leaving reset never looks like an edge.
  localparam logic              IDLE_PIN  = ACTIVE_LOW;

  logic [1:0]        sync_q;
  pb_state_e         state_q, state_d;
  logic [DB_W-1:0]   cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  logic              pin_pressed;
  logic [HOLD_W-1:0] hold_inc;
  logic              hold_hit;

  // Two-flop synchroniser bringing the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= {2{IDLE_PIN}};
    end else begin
      sync_q <= {sync_q[0], pb_raw_i};
    end
  end

  // Normalise to pressed = 1 regardless of board polarity.
  assign pin_pressed = ACTIVE_LOW ? ~sync_q[1] : sync_q[1];

  // The hold counter saturates at the long-press threshold; the strobe is
  // raised on the single step that lands on the threshold.
  assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : (hold_q + HOLD_ONE);
  assign hold_hit = (hold_q == HOLD_LAST);

  // Next-state, counter and strobe decode for the channel FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    case (state_q)
      RELEASED: begin
        if (pin_pressed) begin
          state_d = PRESS_PEND;
          cnt_d   = DB_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      PRESS_PEND: begin
        if (!pin_pressed) begin
          // Glitch: drop back silently.
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == DB_MAX) begin
          state_d = PRESSED;
          cnt_d   = '0;
          hold_d  = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + DB_ONE;
        end
      end

      PRESSED: begin
        hold_d = hold_inc;
        long_d = hold_hit;
        if (!pin_pressed) begin
          state_d = RELEASE_PEND;
          cnt_d   = DB_ONE;
        end else begin
          cnt_d   = '0;
        end
      end

      RELEASE_PEND: begin
        if (pin_pressed) begin
          // Release bounce: the press continues, hold time keeps counting.
          state_d = PRESSED;
          cnt_d   = '0;
          hold_d  = hold_inc;
          long_d  = hold_hit;
        end else if (cnt_q == DB_MAX) begin
          // The press ends here, so a hold threshold reached on this same
          // edge does not count.
          state_d   = RELEASED;
          cnt_d     = '0;
          hold_d    = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d  = cnt_q + DB_ONE;
          hold_d = hold_inc;
          long_d = hold_hit;
        end
      end

      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
        hold_d  = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= RELEASED;
      cnt_q     <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign level_o      = level_q;
  assign level_next_o = level_d;
  assign press_o      = press_q;
  assign release_o    = release_q;
  assign long_o       = long_q;

endmodule : pb_debounce_ch
`default_nettype wire

// File: rtl/pb_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pb_debounce
//  Description : Multi-channel pushbutton conditioner. Replicates one
//                independent debounce channel per button and provides a
//                registered any-button-pressed flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_debounce
  import pb_pkg::*;
#(
  parameter int N_BTN             = 4,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int LONG_PRESS_CYCLES = 50000000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] pb_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             any_pressed
);

  logic [N_BTN-1:0] level_d;
  logic             any_pressed_q;

  generate
    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      pb_debounce_ch #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .ACTIVE_LOW        (ACTIVE_LOW)
      ) u_ch (
        .clk          (clk),
        .reset_n      (reset_n),
        .pb_raw_i     (pb_raw[i]),
        .level_o      (btn_level[i]),
        .level_next_o (level_d[i]),
        .press_o      (btn_press[i]),
        .release_o    (btn_release[i]),
        .long_o       (btn_long[i])
      );
    end
  endgenerate

  // Registered OR of the next levels so any_pressed moves with btn_level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_pressed_q <= 1'b0;
    end else begin
      any_pressed_q <= |level_d;
    end
  end

  assign any_pressed = any_pressed_q;

endmodule : pb_debounce
`default_nettype wire
